// File: rtl/mul4x4_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul4x4_seq (with helper rca4)
// Description : Sequential 4x4 unsigned shift-and-add multiplier. One add-and-
//               shift step per clock through a single ripple-carry adder,
//               registered 8-bit product and a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// rca4 : 4-bit ripple-carry adder, the only adder in the multiplier datapath.
// ----------------------------------------------------------------------------
module rca4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] carry;

   assign carry[0] = cin;

   generate
      for (genvar i = 0; i < 4; i++) begin : g_fa
         assign sum[i]       = a[i] ^ b[i] ^ carry[i];
         assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign cout = carry[4];

endmodule

// ----------------------------------------------------------------------------
// mul4x4_seq : control FSM and shift-and-add datapath around rca4.
// ----------------------------------------------------------------------------
module mul4x4_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       busy,
   output logic       done,
   output logic [7:0] p
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] m;
   logic [3:0] acc;
   logic [3:0] q;
   logic [1:0] cnt;

   logic [3:0] add_sum;
   logic       add_cout;
   logic [3:0] step_s;
   logic       step_c;

   // Single adder: upper partial product plus multiplicand, no carry in.
   rca4 u_add (
      .a    (acc),
      .b    (m),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Select the adder result when the current multiplier bit is set, else pass acc through.
   always_comb begin
      step_c = 1'b0;
      step_s = acc;
      if (q[0]) begin
         step_c = add_cout;
         step_s = add_sum;
      end
   end

   // Control FSM and datapath registers; busy/done/p are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         p     <= 8'h00;
         acc   <= 4'd0;
         q     <= 4'd0;
         m     <= 4'd0;
         cnt   <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  m     <= a;
                  q     <= b;
                  acc   <= 4'd0;
                  cnt   <= 2'd0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               acc <= {step_c, step_s[3:1]};
               q   <= {step_s[0], q[3:1]};
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  // Capture the post-shift {acc,q} as the final product.
                  p     <= {step_c, step_s[3:1], step_s[0], q[3:1]};
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mul4x4_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul4x4_seq
// Description : Self-checking bench for mul4x4_seq. Expected products come
//               from plain multiplication; expected timing is 5 clocks from
//               the accepting edge to done, 6 clocks between accepts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul4x4_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [7:0] p;

   int checks   = 0;
   int failures = 0;

   mul4x4_seq dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one multiplication at the current negedge, scramble the operands
   // after acceptance, and wait (bounded) for done. Returns negedges to done,
   // cycles busy was seen, and p at the done cycle. Ends one negedge after done.
   task automatic do_mul(input logic [3:0] x, input logic [3:0] y,
                         output int lat, output int busy_cnt, output logic [7:0] res);
      a = x; b = y; start = 1'b1;
      busy_cnt = 0;
      res = 8'hxx;
      @(negedge clk);
      start = 1'b0;
      a = 4'($urandom); b = 4'($urandom);
      lat = 1;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      res = p;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a = 4'd5; b = 4'd5;
      @(negedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (p !== 8'h00) begin failures++; $display("FAIL reset_p got=%0d exp=0", p); end
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_no_accept got=%b exp=0", busy); end
   endtask

   task automatic test_basic();
      int lat, bc; logic [7:0] res;
      do_mul(4'd3, 4'd5, lat, bc, res);
      checks++; if (lat != 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", lat); end
      checks++; if (bc != 4) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
      checks++; if (res !== 8'd15) begin failures++; $display("FAIL basic_p got=%0d exp=15", res); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
      repeat (3) @(negedge clk);
      checks++; if (p !== 8'd15) begin failures++; $display("FAIL basic_p_hold got=%0d exp=15", p); end
   endtask

   task automatic test_corners();
      int lat, bc; logic [7:0] res;
      logic [3:0] xs [3] = '{4'd15, 4'd0, 4'd9};
      logic [3:0] ys [3] = '{4'd15, 4'd9, 4'd0};
      for (int i = 0; i < 3; i++) begin
         do_mul(xs[i], ys[i], lat, bc, res);
         checks++;
         if (res !== 8'(xs[i] * ys[i]) || lat != 5) begin
            failures++;
            $display("FAIL corner_%0dx%0d got p=%0d lat=%0d exp p=%0d lat=5",
                     xs[i], ys[i], res, lat, xs[i] * ys[i]);
         end
      end
   endtask

   task automatic test_held_start();
      int prev = 0;
      int ndone = 0;
      a = 4'd7; b = 4'd6; start = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            checks++;
            if (p !== 8'd42) begin failures++; $display("FAIL held_p got=%0d exp=42", p); end
            checks++;
            if (busy !== 1'b0) begin failures++; $display("FAIL held_busy_in_done got=%b exp=0", busy); end
            checks++;
            if ((prev == 0 && i != 5) || (prev != 0 && i - prev != 6)) begin
               failures++;
               $display("FAIL held_spacing got=%0d exp=%0d", i - prev, (prev == 0) ? 5 : 6);
            end
            prev = i;
         end
      end
      checks++; if (ndone != 4) begin failures++; $display("FAIL held_count got=%0d exp=4", ndone); end
      start = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_ignore_start();
      int lat = 1;
      int extra = 0;
      a = 4'd2; b = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 4'd15; b = 4'd15;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 3;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++; if (p !== 8'd6 || lat != 5) begin failures++; $display("FAIL ignore_p got p=%0d lat=%0d exp p=6 lat=5", p, lat); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy || done) extra++;
      end
      checks++; if (extra != 0) begin failures++; $display("FAIL ignore_second_run got=%0d exp=0", extra); end
   endtask

   task automatic test_reset_mid();
      int lat, bc; logic [7:0] res;
      int stray = 0;
      do_mul(4'd4, 4'd4, lat, bc, res);
      checks++; if (res !== 8'd16) begin failures++; $display("FAIL rmid_first_p got=%0d exp=16", res); end
      a = 4'd9; b = 4'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || p !== 8'h00) begin
         failures++;
         $display("FAIL rmid_state got busy=%b done=%b p=%0d exp 0 0 0", busy, done, p);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (busy || done) stray++;
      end
      checks++; if (stray != 0) begin failures++; $display("FAIL rmid_discard got=%0d exp=0", stray); end
      do_mul(4'd9, 4'd9, lat, bc, res);
      checks++; if (res !== 8'd81 || lat != 5) begin failures++; $display("FAIL rmid_rerun got p=%0d lat=%0d exp p=81 lat=5", res, lat); end
   endtask

   task automatic test_random();
      int lat, bc; logic [7:0] res;
      logic [3:0] x, y;
      for (int i = 0; i < 40; i++) begin
         x = 4'($urandom); y = 4'($urandom);
         do_mul(x, y, lat, bc, res);
         checks++;
         if (res !== 8'(x * y) || lat != 5 || bc != 4) begin
            failures++;
            $display("FAIL random_%0dx%0d got p=%0d lat=%0d busy=%0d exp p=%0d lat=5 busy=4",
                     x, y, res, lat, bc, x * y);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat, bc; logic [7:0] res;
      for (int i = 0; i < 256; i++) begin
         do_mul(i[7:4], i[3:0], lat, bc, res);
         checks++;
         if (res !== 8'(i[7:4] * i[3:0]) || lat != 5) begin
            failures++;
            $display("FAIL exhaustive_%0dx%0d got p=%0d lat=%0d exp p=%0d lat=5",
                     i[7:4], i[3:0], res, lat, i[7:4] * i[3:0]);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
      test_reset();
      test_basic();
      test_corners();
      test_held_start();
      test_ignore_start();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
